int8_array_sched: RTL and testbench
===================================

Name: int8_array_sched

Overview:
- Run-sequencer for one int8 systolic PE array with LABFT checksum row/column.
- Sequences four phases per job: weight preload (drives the PE stationary-operand enable), activation streaming, pipeline drain, then checksum verification of the array outputs.
- Sits between the job/DMA front end and the PE grid. Raises a sticky fault flag and keeps a count of checksum mismatches.

Parameters:
- ROWS, 4, PE rows; weight-load beats per job.
- COLS, 4, PE columns.
- K_MAX, 1024, maximum activation stream length.
- MAC_LAT, 2, PE MAC pipeline latency in clk cycles.
- outputBits, 32, accumulator and checksum width.
- ERR_CNT_BITS, 8, mismatch counter width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns FSM to IDLE.
- k_len  in  $clog2(K_MAX+1)  activation beats for the job; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- w_req  out  1  high in LOAD.
- w_valid  in  1  weight row present.
- e_enable  out  1  = w_req & w_valid (combinational); drives PE e_enable.
- w_row  out  $clog2(ROWS)  index of the weight row being loaded.
- act_req  out  1  high in STREAM.
- act_valid  in  1  activation beat present.
- feed_en  out  1  = act_req & act_valid; advances the skew feeders.
- chk_valid  in  1  row result from the collector: data_sum and chk_val are valid.
- data_sum  in  outputBits  modular sum of the COLS data outputs of one row.
- chk_val  in  outputBits  LABFT checksum-column output for the same row.
- err_flag  out  1  sticky mismatch flag; cleared by an accepted start.
- err_cnt  out  ERR_CNT_BITS  mismatch count; saturates; cleared by an accepted start.

Behaviour:
- States: IDLE, LOAD, STREAM, DRAIN, CHECK, DONE. State is encoded in a registered state register.
- Reset: state=IDLE. All counters 0. busy=0, done=0, w_req=0, act_req=0, err_flag=0, err_cnt=0. e_enable and feed_en are therefore 0.
- IDLE:
  - start=1 and k_len!=0: latch k_len, clear err_flag/err_cnt, go to LOAD next cycle.
  - start=1 and k_len==0: done pulses next cycle; state stays IDLE; errors are cleared.
- LOAD:
  - Each cycle with w_valid=1, w_row increments.
  - The beat with w_row==ROWS-1 and w_valid=1 moves the FSM to STREAM.
  - w_valid=0 stalls: e_enable=0, so the PEs hold their weights via recirculation.
- STREAM:
  - Each feed_en beat increments the k counter.
  - The beat that makes the count equal to the latched k_len moves the FSM to DRAIN.
  - act_valid=0 stalls with no count.
- DRAIN:
  - Fixed wait of ROWS+COLS+MAC_LAT cycles, independent of any input, then go to CHECK.
- CHECK:
  - Each chk_valid=1 compares data_sum against chk_val at full outputBits width, mod 2^outputBits.
  - A mismatch sets err_flag and increments err_cnt, saturating at all-ones.
  - After the ROWS-th chk_valid, go to DONE. err_flag/err_cnt reflect that last row in the same cycle done is asserted.
  - chk_valid outside CHECK is ignored.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: with no stalls, start to done = 1 + ROWS + k_len + (ROWS+COLS+MAC_LAT) + ROWS(check, chk_valid back-to-back) + 1 cycles.
- abort:
  - In any non-IDLE state, abort forces IDLE next cycle, with no done pulse.
  - e_enable and feed_en are 0 in the abort cycle.
  - err_flag/err_cnt are held.
  - abort has priority over every other transition.
- start while busy is ignored.
- Asynchronous rst mid-job returns to the reset state immediately.

Decomposition:
- Package int8_array_pkg:
  - sched_state_t enum.
  - DRAIN_CYCLES localparam function of ROWS, COLS, MAC_LAT.
- Sub-module labft_chk_cmp:
  - Registered compare plus saturating err counter.
  - Interface: clk, rst, clr, en, data_sum, chk_val, err_flag, err_cnt.

Test Plan:
- Nominal job:
  - Stimulus: ROWS=COLS=4, MAC_LAT=2, k_len=8, w_valid/act_valid tied 1, 4 matching chk rows.
  - Response: e_enable high 4 cycles, feed_en high 8 cycles, DRAIN 10 cycles, done at cycle 28 after start, err_flag=0.
- Stalls:
  - Stimulus: w_valid toggles 1,0,1,0… and act_valid has a 3-cycle gap.
  - Response: exactly 4 e_enable pulses and 8 feed_en pulses; w_row sequence 0..3; done delayed by the stall count.
- Checksum fault:
  - Stimulus: row 2 has data_sum=0x0000_0010, chk_val=0x0000_0011.
  - Response: err_flag=1 from the cycle after that compare; err_cnt=1; done still asserted; next start clears both.
- Saturation:
  - Stimulus: ERR_CNT_BITS=2, three jobs all mismatching, no start between compares (start only clears).
  - Response: within a job of 4 bad rows, err_cnt goes 1,2,3,3.
- k_len=0 and ignored start:
  - Stimulus: start with k_len=0; then a start pulsed during STREAM.
  - Response: done one cycle later with busy never high; the second start causes no restart and no count change.
- Abort/reset:
  - Stimulus: abort in STREAM after 3 beats; separately, rst asserted in CHECK.
  - Response: IDLE next cycle with no done and busy=0. rst clears all outputs asynchronously; a subsequent job runs nominally.

Source files
------------

// File: rtl/int8_array_sched_pkg.sv
// Shared types and helpers for the int8 systolic-array run sequencer.
package int8_array_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_LOAD   = S_LOAD,
    ST_STREAM = S_STREAM,
    ST_DRAIN  = S_DRAIN,
    ST_CHECK  = S_CHECK,
    ST_DONE   = S_DONE
  } sched_state_t;

  // Cycles for the last activation to ripple through the skewed grid and MAC pipe.
  function automatic int unsigned drain_cycles(input int unsigned rows,
                                               input int unsigned cols,
                                               input int unsigned mac_lat);
    return rows + cols + mac_lat;
  endfunction

endpackage

// File: rtl/int8_array_sched_if.sv
// Job, weight/activation handshake and checksum bus between front end and sequencer.
interface int8_array_sched_if #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned K_MAX        = 1024,
  parameter int unsigned outputBits   = 32,
  parameter int unsigned ERR_CNT_BITS = 8
);
  localparam int unsigned KW = $clog2(K_MAX + 1);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                    start;
  logic                    abort;
  logic [KW-1:0]           k_len;
  logic                    busy;
  logic                    done;
  logic                    w_req;
  logic                    w_valid;
  logic                    e_enable;
  logic [RW-1:0]           w_row;
  logic                    act_req;
  logic                    act_valid;
  logic                    feed_en;
  logic                    chk_valid;
  logic [outputBits-1:0]   data_sum;
  logic [outputBits-1:0]   chk_val;
  logic                    err_flag;
  logic [ERR_CNT_BITS-1:0] err_cnt;

  modport master (
    output start, abort, k_len, w_valid, act_valid, chk_valid, data_sum, chk_val,
    input  busy, done, w_req, e_enable, w_row, act_req, feed_en, err_flag, err_cnt
  );

  modport slave (
    input  start, abort, k_len, w_valid, act_valid, chk_valid, data_sum, chk_val,
    output busy, done, w_req, e_enable, w_row, act_req, feed_en, err_flag, err_cnt
  );
endinterface

// File: rtl/int8_array_sched_labft_chk_cmp.sv
// LABFT row compare: flags data_sum != chk_val and counts mismatches (saturating).
module labft_chk_cmp #(
  parameter int unsigned outputBits   = 32,
  parameter int unsigned ERR_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [outputBits-1:0]   data_sum,
  input  logic [outputBits-1:0]   chk_val,
  output logic                    err_flag,
  output logic [ERR_CNT_BITS-1:0] err_cnt
);

  // Sticky flag and saturating count, cleared when a new job is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else if (clr) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else if (en && (data_sum != chk_val)) begin
      err_flag <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/int8_array_sched.sv
// Run sequencer: weight preload, activation stream, drain, checksum check.
module int8_array_sched #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned K_MAX        = 1024,
  parameter int unsigned MAC_LAT      = 2,
  parameter int unsigned outputBits   = 32,
  parameter int unsigned ERR_CNT_BITS = 8
) (
  input logic              clk,
  input logic              rst,
  int8_array_sched_if.slave bus
);
  import int8_array_pkg::*;

  localparam int unsigned KW           = $clog2(K_MAX + 1);
  localparam int unsigned RW           = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DRAIN_CYCLES = drain_cycles(ROWS, COLS, MAC_LAT);

  sched_state_t  state;
  logic [RW-1:0] w_row_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] cnt;
  logic          done_q;

  logic idle, clr, accept, zero_job, abort_hit;
  logic load_beat, stream_beat, chk_beat;
  logic last_w, last_a, drain_end, last_c;

  assign idle        = (state == ST_IDLE);
  assign clr         = idle & bus.start;
  assign accept      = clr & (bus.k_len != '0);
  assign zero_job    = clr & (bus.k_len == '0);
  assign abort_hit   = bus.abort & ~idle;

  assign load_beat   = (state == ST_LOAD)   & bus.w_valid   & ~bus.abort;
  assign stream_beat = (state == ST_STREAM) & bus.act_valid & ~bus.abort;
  assign chk_beat    = (state == ST_CHECK)  & bus.chk_valid & ~bus.abort;

  assign last_w      = load_beat   & (w_row_q == RW'(ROWS - 1));
  assign last_a      = stream_beat & (cnt == k_q - KW'(1));
  assign drain_end   = (state == ST_DRAIN) & (cnt == KW'(DRAIN_CYCLES - 1));
  assign last_c      = chk_beat    & (cnt == KW'(ROWS - 1));

  assign bus.busy     = ~idle;
  assign bus.done     = done_q;
  assign bus.w_req    = (state == ST_LOAD);
  assign bus.act_req  = (state == ST_STREAM);
  assign bus.e_enable = load_beat;
  assign bus.feed_en  = stream_beat;
  assign bus.w_row    = w_row_q;

  // Phase sequencing; abort overrides every other transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (abort_hit) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (accept)    state <= ST_LOAD;
        ST_LOAD:   if (last_w)    state <= ST_STREAM;
        ST_STREAM: if (last_a)    state <= ST_DRAIN;
        ST_DRAIN:  if (drain_end) state <= ST_CHECK;
        ST_CHECK:  if (last_c)    state <= ST_DONE;
        ST_DONE:                  state <= ST_IDLE;
        default:                  state <= ST_IDLE;
      endcase
    end
  end

  // Weight row index and latched job length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_row_q <= '0;
      k_q     <= '0;
    end else if (accept) begin
      w_row_q <= '0;
      k_q     <= bus.k_len;
    end else if (load_beat) begin
      w_row_q <= last_w ? '0 : w_row_q + RW'(1);
    end
  end

  // One counter serves stream beats, drain cycles and checked rows in turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept || abort_hit) begin
      cnt <= '0;
    end else if (stream_beat) begin
      cnt <= last_a ? '0 : cnt + KW'(1);
    end else if (state == ST_DRAIN) begin
      cnt <= drain_end ? '0 : cnt + KW'(1);
    end else if (chk_beat) begin
      cnt <= last_c ? '0 : cnt + KW'(1);
    end
  end

  // Single-cycle done, for both a completed job and a zero-length request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= zero_job | last_c;
  end

  labft_chk_cmp #(
    .outputBits  (outputBits),
    .ERR_CNT_BITS(ERR_CNT_BITS)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .en      (chk_beat),
    .data_sum(bus.data_sum),
    .chk_val (bus.chk_val),
    .err_flag(bus.err_flag),
    .err_cnt (bus.err_cnt)
  );

endmodule

// File: tb/tb_int8_array_sched.sv
// Randomized bench for int8_array_sched against a beat-counting job model.
module tb_int8_array_sched;
  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLS    = 4;
  localparam int unsigned K_MAX   = 1024;
  localparam int unsigned MAC_LAT = 2;
  localparam int unsigned OB      = 32;
  localparam int unsigned EB      = 2;
  localparam int unsigned KW      = $clog2(K_MAX + 1);
  localparam int unsigned RW      = $clog2(ROWS);
  localparam int unsigned DRAIN   = ROWS + COLS + MAC_LAT;
  localparam int unsigned ECNT_MAX = (1 << EB) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int8_array_sched_if #(.ROWS(ROWS), .K_MAX(K_MAX), .outputBits(OB), .ERR_CNT_BITS(EB)) ifc ();

  int8_array_sched #(
    .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .MAC_LAT(MAC_LAT),
    .outputBits(OB), .ERR_CNT_BITS(EB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Job model: progress is tracked as beats consumed per phase.
  bit          m_busy, m_done, m_eflag;
  int unsigned m_ecnt, m_k, m_w, m_a, m_d, m_c;

  function automatic bit active();    return m_busy && !m_done; endfunction
  function automatic bit in_load();   return active() && m_w < ROWS; endfunction
  function automatic bit in_stream(); return active() && m_w == ROWS && m_a < m_k; endfunction
  function automatic bit in_drain();  return active() && m_w == ROWS && m_a == m_k && m_d < DRAIN; endfunction
  function automatic bit in_check();  return active() && m_d == DRAIN && m_c < ROWS; endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_eflag = 0; m_ecnt = 0;
    m_k = 0; m_w = 0; m_a = 0; m_d = 0; m_c = 0;
  endtask

  task automatic model_step();
    bit nd = 0;
    if (!m_busy) begin
      if (ifc.start) begin
        m_eflag = 0; m_ecnt = 0;
        if (ifc.k_len == 0) nd = 1;
        else begin
          m_busy = 1; m_k = ifc.k_len;
          m_w = 0; m_a = 0; m_d = 0; m_c = 0;
        end
      end
    end else if (ifc.abort || m_done) begin
      m_busy = 0;
    end else if (in_load()) begin
      if (ifc.w_valid) m_w++;
    end else if (in_stream()) begin
      if (ifc.act_valid) m_a++;
    end else if (in_drain()) begin
      m_d++;
    end else if (in_check() && ifc.chk_valid) begin
      if (ifc.data_sum != ifc.chk_val) begin
        m_eflag = 1;
        if (m_ecnt < ECNT_MAX) m_ecnt++;
      end
      m_c++;
      if (m_c == ROWS) nd = 1;
    end
    m_done = nd;
  endtask

  int  cur_t, e_cnt, f_cnt, done_tick;
  bit  busy_seen;
  logic [RW-1:0] wrow_log[$];

  task automatic check_outputs();
    check_eq("busy", ifc.busy, m_busy);
    check_eq("done", ifc.done, m_done);
    check_eq("w_req", ifc.w_req, in_load());
    check_eq("act_req", ifc.act_req, in_stream());
    check_eq("e_enable", ifc.e_enable, in_load() && ifc.w_valid && !ifc.abort);
    check_eq("feed_en", ifc.feed_en, in_stream() && ifc.act_valid && !ifc.abort);
    if (in_load()) check_eq("w_row", ifc.w_row, m_w);
    check_eq("err_flag", ifc.err_flag, m_eflag);
    check_eq("err_cnt", ifc.err_cnt, m_ecnt);
  endtask

  // Inputs are already driven; compare mid-cycle, then advance the model on the edge.
  task automatic tick();
    #1;
    check_outputs();
    if (ifc.e_enable) begin e_cnt++; wrow_log.push_back(ifc.w_row); end
    if (ifc.feed_en) f_cnt++;
    if (ifc.busy) busy_seen = 1;
    if (ifc.done && done_tick < 0) done_tick = cur_t;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_tick();
    ifc.start = 0; ifc.abort = 0; ifc.k_len = '0;
    ifc.w_valid = 0; ifc.act_valid = 0; ifc.chk_valid = 0;
    ifc.data_sum = '0; ifc.chk_val = '0;
    tick();
  endtask

  task automatic run_job(input int unsigned k, input bit w_toggle,
                         input int unsigned gap_at, input int unsigned gap_len,
                         input logic [ROWS-1:0] bad, input bit noisy,
                         input bit start_in_stream, input int abort_beat, input int rst_row);
    int unsigned gap_left = gap_len;
    bit finished = 0;
    e_cnt = 0; f_cnt = 0; done_tick = -1; busy_seen = 0;
    wrow_log.delete();
    for (int t = 0; t < 4000; t++) begin
      cur_t = t;
      ifc.start = (t == 0) || (start_in_stream && in_stream() && m_a == 2);
      ifc.k_len = (t == 0) ? KW'(k) : KW'($urandom_range(1, 50));
      ifc.abort = (abort_beat >= 0) && in_stream() && (m_a == unsigned'(abort_beat));
      if (w_toggle) ifc.w_valid = (t % 2 == 1);
      else          ifc.w_valid = noisy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (in_stream() && m_a == gap_at && gap_left > 0) begin
        ifc.act_valid = 0;
        gap_left--;
      end else begin
        ifc.act_valid = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      ifc.data_sum = $urandom;
      if (in_check()) begin
        ifc.chk_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bad[m_c]) begin
          ifc.data_sum = 32'h0000_0010;
          ifc.chk_val  = 32'h0000_0011;
        end else begin
          ifc.chk_val = ifc.data_sum;
        end
      end else begin
        ifc.chk_valid = 1'($urandom_range(0, 1));
        ifc.chk_val   = ~ifc.data_sum;
      end
      if (rst_row >= 0 && in_check() && m_c == unsigned'(rst_row)) begin
        #1 rst = 1;
        #1;
        check_eq("rst_busy", ifc.busy, 0);
        check_eq("rst_done", ifc.done, 0);
        check_eq("rst_w_req", ifc.w_req, 0);
        check_eq("rst_act_req", ifc.act_req, 0);
        check_eq("rst_e_enable", ifc.e_enable, 0);
        check_eq("rst_feed_en", ifc.feed_en, 0);
        check_eq("rst_err_flag", ifc.err_flag, 0);
        check_eq("rst_err_cnt", ifc.err_cnt, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        return;
      end
      tick();
      if (!m_busy && !m_done) begin
        finished = 1;
        break;
      end
    end
    if (!finished) check_eq("job_timeout", 1, 0);
  endtask

  task automatic check_wrows(input string tag);
    check_eq({tag, "_wrow_n"}, wrow_log.size(), ROWS);
    for (int i = 0; i < wrow_log.size() && i < ROWS; i++)
      check_eq({tag, "_wrow"}, wrow_log[i], i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog no finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    ifc.start = 0; ifc.abort = 0; ifc.k_len = '0;
    ifc.w_valid = 0; ifc.act_valid = 0; ifc.chk_valid = 0;
    ifc.data_sum = '0; ifc.chk_val = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    check_outputs();
    rst = 0;
    @(negedge clk);
    idle_tick();

    // Nominal job
    run_job(8, 0, 0, 0, '0, 0, 0, -1, -1);
    check_eq("nom_done_tick", done_tick, 1 + ROWS + 8 + DRAIN + ROWS);
    check_eq("nom_e_pulses", e_cnt, ROWS);
    check_eq("nom_f_pulses", f_cnt, 8);
    check_eq("nom_err_flag", ifc.err_flag, 0);
    check_wrows("nom");
    idle_tick();

    // Stalls: 3 weight stalls, 3-cycle activation gap
    run_job(8, 1, 4, 3, '0, 0, 0, -1, -1);
    check_eq("stall_done_tick", done_tick, 1 + ROWS + 8 + DRAIN + ROWS + 6);
    check_eq("stall_e_pulses", e_cnt, ROWS);
    check_eq("stall_f_pulses", f_cnt, 8);
    check_wrows("stall");
    idle_tick();

    // Checksum fault on row 2
    run_job(8, 0, 0, 0, 4'b0100, 0, 0, -1, -1);
    check_eq("fault_done_tick", done_tick, 1 + ROWS + 8 + DRAIN + ROWS);
    check_eq("fault_err_flag", ifc.err_flag, 1);
    check_eq("fault_err_cnt", ifc.err_cnt, 1);
    run_job(3, 0, 0, 0, '0, 0, 0, -1, -1);
    check_eq("clear_err_flag", ifc.err_flag, 0);
    check_eq("clear_err_cnt", ifc.err_cnt, 0);
    idle_tick();

    // Saturation across three all-bad jobs
    for (int j = 0; j < 3; j++) begin
      run_job(2, 0, 0, 0, 4'b1111, 0, 0, -1, -1);
      check_eq("sat_err_cnt", ifc.err_cnt, ECNT_MAX);
      check_eq("sat_err_flag", ifc.err_flag, 1);
    end
    idle_tick();

    // Zero-length request
    run_job(0, 0, 0, 0, '0, 0, 0, -1, -1);
    check_eq("k0_done_tick", done_tick, 1);
    check_eq("k0_busy_seen", busy_seen, 0);
    idle_tick();

    // Start pulsed mid-stream is ignored
    run_job(8, 0, 0, 0, '0, 0, 1, -1, -1);
    check_eq("ign_done_tick", done_tick, 1 + ROWS + 8 + DRAIN + ROWS);
    check_eq("ign_f_pulses", f_cnt, 8);
    idle_tick();

    // Abort after 3 stream beats
    run_job(8, 0, 0, 0, '0, 0, 0, 3, -1);
    check_eq("abort_no_done", done_tick, -1);
    check_eq("abort_f_pulses", f_cnt, 3);
    check_eq("abort_busy", ifc.busy, 0);
    idle_tick();

    // Reset during CHECK, then a clean job
    run_job(5, 0, 0, 0, 4'b0001, 0, 0, -1, 1);
    idle_tick();
    run_job(8, 0, 0, 0, '0, 0, 0, -1, -1);
    check_eq("post_rst_done_tick", done_tick, 1 + ROWS + 8 + DRAIN + ROWS);
    check_eq("post_rst_e_pulses", e_cnt, ROWS);
    idle_tick();

    // Randomized jobs
    for (int j = 0; j < 12; j++) begin
      int unsigned k;
      int ab;
      k  = $urandom_range(1, 12);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, k - 1)) : -1;
      run_job(k, 0, 0, 0, ROWS'($urandom), 1, 0, ab, -1);
      if (ab < 0) begin
        check_eq("rnd_e_pulses", e_cnt, ROWS);
        check_eq("rnd_f_pulses", f_cnt, k);
      end
      idle_tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
